// File: rtl/rv_mt_pkg.sv
// Shared defaults, index typedefs and FSM state encoding for the multi-thread register file.
// Optional same-edge write-to-read bypass is enabled by defining RV_MT_RF_BYPASS_EN.
package rv_mt_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned NTHREADS_DEF = 4;
    localparam int unsigned NREGS_DEF    = 32;

    localparam int unsigned TW_DEF = $clog2(NTHREADS_DEF);
    localparam int unsigned AW_DEF = $clog2(NREGS_DEF);

    typedef logic [TW_DEF-1:0] tid_t;
    typedef logic [AW_DEF-1:0] reg_idx_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rv_mt_rf_bank.sv
// One thread's register bank: two read ports and one synchronous write port.
// Read data is combinational here; the top registers it into the read-port outputs.
module rv_mt_rf_bank
    import rv_mt_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_c_o,
    output logic [XLEN-1:0] rdata2_c_o
);

    // Storage is deliberately not reset; the top's clear sweep zeroes it.
    logic [XLEN-1:0] mem_q [NREGS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_c_o = mem_q[raddr1_i];
    assign rdata2_c_o = mem_q[raddr2_i];

endmodule

// File: rtl/rv_mt_reg_file.sv
// Multi-thread 2R1W register file: per-thread banks, x0 hardwired to zero, zeroing sweep after reset.
// Define RV_MT_RF_BYPASS_EN to forward a same-edge write to a matching read.
module rv_mt_reg_file
    import rv_mt_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NTHREADS = NTHREADS_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    localparam int unsigned TW      = $clog2(NTHREADS),
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [TW-1:0]   rd_tid,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_out,
    output logic [XLEN-1:0] rs2_out,
    input  logic [TW-1:0]   wr_tid,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] rd_data,
    input  logic            we,
    output logic            ready
);

    localparam int unsigned CW = TW + AW;

    rf_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic [XLEN-1:0] rs1_out_q, rs1_out_d;
    logic [XLEN-1:0] rs2_out_q, rs2_out_d;

    logic            wr_commit;
    logic            wr_en;
    logic [TW-1:0]   wr_bank;
    logic [AW-1:0]   wr_idx;
    logic [XLEN-1:0] wr_val;

    logic [XLEN-1:0] bank_rdata1 [NTHREADS];
    logic [XLEN-1:0] bank_rdata2 [NTHREADS];

    assign wr_commit = (state_q == ST_READY) && we && (rd != '0);

    // Write port mux: the sweep owns the banks until the block is ready.
    always_comb begin
        wr_en   = wr_commit;
        wr_bank = wr_tid;
        wr_idx  = rd;
        wr_val  = rd_data;
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_bank = cnt_q[CW-1:AW];
            wr_idx  = cnt_q[AW-1:0];
            wr_val  = '0;
        end
    end

    for (genvar t = 0; t < NTHREADS; t++) begin : g_bank
        rv_mt_rf_bank #(
            .XLEN  (XLEN),
            .NREGS (NREGS)
        ) u_bank (
            .clk        (clk),
            .we_i       (wr_en && (wr_bank == TW'(t))),
            .waddr_i    (wr_idx),
            .wdata_i    (wr_val),
            .raddr1_i   (rs1),
            .raddr2_i   (rs2),
            .rdata1_c_o (bank_rdata1[t]),
            .rdata2_c_o (bank_rdata2[t])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            rs1_out_q <= '0;
            rs2_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            rs1_out_q <= rs1_out_d;
            rs2_out_q <= rs2_out_d;
        end
    end

    // Sweep sequencing plus read-data selection with x0 masking.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rs1_out_d = '0;
        rs2_out_d = '0;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + CW'(1);
                if (&cnt_q) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (rs1 != '0) rs1_out_d = bank_rdata1[rd_tid];
                if (rs2 != '0) rs2_out_d = bank_rdata2[rd_tid];
`ifdef RV_MT_RF_BYPASS_EN
                // wr_commit already excludes rd==0, so x0 stays zero.
                if (wr_commit && (wr_tid == rd_tid) && (rs1 == rd)) rs1_out_d = rd_data;
                if (wr_commit && (wr_tid == rd_tid) && (rs2 == rd)) rs2_out_d = rd_data;
`endif
            end
            default: state_d = ST_CLEAR;
        endcase
        ready_d = (state_d == ST_READY);
    end

    assign rs1_out = rs1_out_q;
    assign rs2_out = rs2_out_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_rv_mt_reg_file.sv
// Directed bench for rv_mt_reg_file: default instance plus a 2-thread/16-reg/64-bit instance.
// Read expectations are queued when a read is driven and checked after the sampling edge.
module tb_rv_mt_reg_file;

`ifdef RV_MT_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0]  rd_tid, wr_tid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd_data, rs1_out, rs2_out;
    logic        we, ready;

    logic [0:0]  b_rd_tid, b_wr_tid;
    logic [3:0]  b_rs1, b_rs2, b_rd;
    logic [63:0] b_rd_data, b_rs1_out, b_rs2_out;
    logic        b_we, b_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        int          id;
    } exp_t;
    exp_t exp_q[$];
    int   next_id = 0;

    always #5 clk = ~clk;

    rv_mt_reg_file dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_tid  (rd_tid),
        .rs1     (rs1),
        .rs2     (rs2),
        .rs1_out (rs1_out),
        .rs2_out (rs2_out),
        .wr_tid  (wr_tid),
        .rd      (rd),
        .rd_data (rd_data),
        .we      (we),
        .ready   (ready)
    );

    rv_mt_reg_file #(
        .XLEN     (64),
        .NTHREADS (2),
        .NREGS    (16)
    ) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_tid  (b_rd_tid),
        .rs1     (b_rs1),
        .rs2     (b_rs2),
        .rs1_out (b_rs1_out),
        .rs2_out (b_rs2_out),
        .wr_tid  (b_wr_tid),
        .rd      (b_rd),
        .rd_data (b_rd_data),
        .we      (b_we),
        .ready   (b_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; compare any read queued for that edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("read%0d_rs1", e.id), {32'h0, rs1_out}, {32'h0, e.r1});
            check($sformatf("read%0d_rs2", e.id), {32'h0, rs2_out}, {32'h0, e.r2});
        end
    endtask

    task automatic rd_step(input logic [1:0] tid, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        rd_tid = tid;
        rs1    = a1;
        rs2    = a2;
        e.r1   = e1;
        e.r2   = e2;
        e.id   = next_id;
        next_id++;
        exp_q.push_back(e);
        tick();
    endtask

    task automatic wr_set(input logic [1:0] tid, input logic [4:0] idx, input logic [31:0] val);
        we      = 1'b1;
        wr_tid  = tid;
        rd      = idx;
        rd_data = val;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_set(2'd0, 5'd4, 32'hAAAA_5555);
        rd_tid  = 2'd0;
        rs1     = 5'd4;
        rs2     = 5'd5;
        b_we      = 1'b1;
        b_wr_tid  = 1'b1;
        b_rd      = 4'd15;
        b_rd_data = '1;
        b_rd_tid  = 1'b1;
        b_rs1     = 4'd15;
        b_rs2     = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {63'h0, ready}, 64'h0);
        check("rst_rs1", {32'h0, rs1_out}, 64'h0);
        check("rst_rs2", {32'h0, rs2_out}, 64'h0);
        check("rst_b_ready", {63'h0, b_ready}, 64'h0);
        #2 rst_n = 1'b1;

        // Sweep with write enable held high; nothing may land or show on the read ports.
        for (int i = 1; i <= 128; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("sweep_ready_e%0d", i), {63'h0, ready}, {63'h0, (i == 128)});
            check($sformatf("sweep_rs1_e%0d", i), {32'h0, rs1_out}, 64'h0);
            check($sformatf("sweep_b_ready_e%0d", i), {63'h0, b_ready}, {63'h0, (i >= 32)});
            if (i == 31) b_we = 1'b0;
        end
        we = 1'b0;

        rd_step(2'd0, 5'd4, 5'd1, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("b_sweep_write_lost", b_rs1_out, 64'h0);

        wr_set(2'd0, 5'd4, 32'h77);
        rd_step(2'd1, 5'd4, 5'd4, 32'h0, 32'h0);
        we = 1'b0;
        rd_step(2'd0, 5'd4, 5'd0, 32'h77, 32'h0);
        rd_step(2'd1, 5'd4, 5'd4, 32'h0, 32'h0);

        wr_set(2'd2, 5'd0, 32'hDEAD_BEEF);
        rd_step(2'd2, 5'd0, 5'd0, 32'h0, 32'h0);
        we = 1'b0;
        rd_step(2'd2, 5'd0, 5'd0, 32'h0, 32'h0);

        wr_set(2'd1, 5'd5, 32'h1234);
        rd_step(2'd1, 5'd5, 5'd5, BYP ? 32'h1234 : 32'h0, BYP ? 32'h1234 : 32'h0);
        we = 1'b0;
        rd_step(2'd3, 5'd0, 5'd5, 32'h0, 32'h0);
        rd_step(2'd1, 5'd5, 5'd0, 32'h1234, 32'h0);

        wr_set(2'd3, 5'd9, 32'h9999);
        rd_step(2'd3, 5'd1, 5'd9, 32'h0, BYP ? 32'h9999 : 32'h0);
        we = 1'b0;
        rd_step(2'd3, 5'd9, 5'd9, 32'h9999, 32'h9999);

        // Distinct register per thread; each neighbour's register must read 0 elsewhere.
        for (int t = 0; t < 4; t++) begin
            wr_set(2'(t), 5'(10 + t), 32'hC0DE_0000 | 32'(t << 8) | 32'(10 + t));
            tick();
        end
        we = 1'b0;
        for (int t = 0; t < 4; t++) begin
            rd_step(2'(t), 5'(10 + t), 5'(10 + ((t + 1) % 4)),
                    32'hC0DE_0000 | 32'(t << 8) | 32'(10 + t), 32'h0);
        end

        wr_set(2'd0, 5'd7, 32'h55);
        tick();
        we = 1'b0;
        rd_step(2'd0, 5'd7, 5'd7, 32'h55, 32'h55);

        // Mid-operation reset pulse must clear outputs at once and restart the sweep.
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rs1", {32'h0, rs1_out}, 64'h0);
        check("midrst_rs2", {32'h0, rs2_out}, 64'h0);
        check("midrst_ready", {63'h0, ready}, 64'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 1; i <= 128; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("resweep_ready_e%0d", i), {63'h0, ready}, {63'h0, (i == 128)});
        end
        rd_step(2'd0, 5'd7, 5'd0, 32'h0, 32'h0);

        b_we      = 1'b1;
        b_wr_tid  = 1'b1;
        b_rd      = 4'd15;
        b_rd_data = 64'hFFFF_FFFF_0000_0001;
        @(posedge clk);
        #1;
        b_we     = 1'b0;
        b_rd_tid = 1'b1;
        b_rs1    = 4'd15;
        b_rs2    = 4'd15;
        @(posedge clk);
        #1;
        check("b_rt_rs1", b_rs1_out, 64'hFFFF_FFFF_0000_0001);
        check("b_rt_rs2", b_rs2_out, 64'hFFFF_FFFF_0000_0001);
        b_rd_tid = 1'b0;
        @(posedge clk);
        #1;
        check("b_other_thread", b_rs1_out, 64'h0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
